// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: default widths and
// FSM state encodings used by the top level.
package alu_cmd_sequencer_pkg;

  // Default geometry of the attached ALU and the command buffer
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned SEL_W_DEF  = 3;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned SETTLE_DEF = 1;

  // FSM state encodings (kept as plain constants for legacy tools)
  typedef logic [1:0] seq_state_t;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command, ALU-drive and result streams of the sequencer.
// slave  : the sequencer itself
// master : the environment (command source, ALU and result consumer)
interface alu_cmd_sequencer_if
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  // Command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [SEL_W-1:0]  cmd_s;

  // ALU drive / sample
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [SEL_W-1:0]  alu_s;
  logic [DATA_W-1:0] alu_y;
  logic              alu_carry;

  // Result stream
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_y;
  logic              res_carry;
  logic              res_zero;
  logic [SEL_W-1:0]  res_s;

  // Status
  logic [CNT_W-1:0]  fifo_count;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_s,
    input  alu_y, alu_carry,
    input  res_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_s,
    output res_valid, res_y, res_carry, res_zero, res_s,
    output fifo_count, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_s,
    output alu_y, alu_carry,
    output res_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_s,
    input  res_valid, res_y, res_carry, res_zero, res_s,
    input  fifo_count, busy
  );

endinterface

// File: rtl/alu_cmd_sequencer_sync_fifo.sv
// Synchronous FIFO with occupancy count. Head entry is presented from
// storage without bypass: a word pushed into an empty FIFO becomes visible
// at the head only after the push edge. DEPTH must be a power of two >= 2.
module sync_fifo
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage write; cleared on reset so the head never shows stale data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Read/write pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for a purely combinational ALU: buffers commands, drives
// registered operands, waits SETTLE cycles, then captures y/carry and
// offers them as a valid/ready result stream.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input logic               clk,
  input logic               rst_n,
  alu_cmd_sequencer_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W  = 2 * DATA_W + SEL_W;
  localparam int unsigned SCNT_W = $clog2(SETTLE + 1);

  // FIFO hookup; entry layout is {a, b, s}
  logic [ENT_W-1:0] w_fifo_wdata;
  logic [ENT_W-1:0] w_fifo_rdata;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_push;
  logic             w_load;
  logic             w_capture;

  // Sequencer state
  seq_state_t        r_state;
  logic [SCNT_W-1:0] r_settle_cnt;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [SEL_W-1:0]  r_alu_s;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_y;
  logic              r_res_carry;
  logic              r_res_zero;
  logic [SEL_W-1:0]  r_res_s;

  assign w_fifo_wdata = {bus.cmd_a, bus.cmd_b, bus.cmd_s};
  assign w_push       = bus.cmd_valid & ~w_fifo_full;

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_load),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Decide when the head command is popped and loaded onto the ALU inputs
  always_comb begin
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_load = 1'b1;
        end else begin
          w_load = 1'b0;
        end
      end
      ST_RESULT: begin
        if (bus.res_ready && !w_fifo_empty) begin
          w_load = 1'b1;
        end else begin
          w_load = 1'b0;
        end
      end
      default: w_load = 1'b0;
    endcase
  end

  // Capture happens on the last settle cycle, when the counter reads one
  always_comb begin
    w_capture = 1'b0;
    if (r_state == ST_SETTLE && r_settle_cnt == SCNT_W'(1)) begin
      w_capture = 1'b1;
    end else begin
      w_capture = 1'b0;
    end
  end

  // State machine and settle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= {SCNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= SCNT_W'(SETTLE);
          end
        end
        ST_SETTLE: begin
          if (w_capture) begin
            r_state <= ST_RESULT;
          end else begin
            r_settle_cnt <= r_settle_cnt - SCNT_W'(1);
          end
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            if (w_load) begin
              r_state      <= ST_SETTLE;
              r_settle_cnt <= SCNT_W'(SETTLE);
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_settle_cnt <= {SCNT_W{1'b0}};
        end
      endcase
    end
  end

  // ALU operands change only on a load and are retained otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a <= {DATA_W{1'b0}};
      r_alu_b <= {DATA_W{1'b0}};
      r_alu_s <= {SEL_W{1'b0}};
    end else if (w_load) begin
      r_alu_a <= w_fifo_rdata[ENT_W-1 -: DATA_W];
      r_alu_b <= w_fifo_rdata[SEL_W +: DATA_W];
      r_alu_s <= w_fifo_rdata[SEL_W-1:0];
    end
  end

  // Result capture; data held stable until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_y     <= {DATA_W{1'b0}};
      r_res_carry <= 1'b0;
      r_res_zero  <= 1'b0;
      r_res_s     <= {SEL_W{1'b0}};
    end else if (w_capture) begin
      r_res_y     <= bus.alu_y;
      r_res_carry <= bus.alu_carry;
      r_res_zero  <= (bus.alu_y == {DATA_W{1'b0}});
      r_res_s     <= r_alu_s;
    end
  end

  // Result valid: set on capture, cleared when the result is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
    end else if (r_state == ST_RESULT && bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.cmd_ready  = ~w_fifo_full;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_s      = r_alu_s;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_y      = r_res_y;
  assign bus.res_carry  = r_res_carry;
  assign bus.res_zero   = r_res_zero;
  assign bus.res_s      = r_res_s;
  assign bus.fifo_count = w_fifo_count;
  assign bus.busy       = (r_state != ST_IDLE) || (w_fifo_count != {CNT_W{1'b0}});

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: table-driven single commands,
// hand-written backpressure/throughput/reset sequences and a randomized run
// checked against a queue-based reference model.
module tb_alu_cmd_sequencer;
  import alu_cmd_sequencer_pkg::*;

  localparam int DW = 8;
  localparam int SW = 3;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.DATA_W(DW), .SEL_W(SW), .DEPTH(DP)) bus ();

  alu_cmd_sequencer #(.DATA_W(DW), .SEL_W(SW), .DEPTH(DP), .SETTLE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Bench ALU: {carry, y}
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    case (s)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a[7], a[6:0], 1'b0};
      3'd7:    return {a[0], 1'b0, a[7:1]};
      default: return 9'd0;
    endcase
  endfunction

  // Combinational ALU attached to the sequencer
  always_comb {bus.alu_carry, bus.alu_y} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_s);

  typedef struct {
    logic [7:0] y;
    logic       c;
    logic       z;
    logic [2:0] s;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] s;
    logic [7:0] exp_y;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    res_t r;
    logic [8:0] cy;
    cy  = alu_fn(a, b, s);
    r.y = cy[7:0];
    r.c = cy[8];
    r.z = (cy[7:0] == 8'd0);
    r.s = s;
    return r;
  endfunction

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_res   = 0;
  res_t exp_q[$];
  int   hs_q[$];
  logic prev_hold = 1'b0;
  res_t prev_res;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One clock with scoreboard tracking of both handshakes and hold stability
  task automatic tick();
    res_t e;
    if (prev_hold) begin
      check("hold_valid", {31'd0, bus.res_valid}, 32'd1);
      check("hold_y", {24'd0, bus.res_y}, {24'd0, prev_res.y});
      check("hold_s", {29'd0, bus.res_s}, {29'd0, prev_res.s});
    end
    prev_hold  = bus.res_valid && !bus.res_ready;
    prev_res.y = bus.res_y;
    prev_res.s = bus.res_s;
    if (bus.cmd_valid && bus.cmd_ready) exp_q.push_back(model(bus.cmd_a, bus.cmd_b, bus.cmd_s));
    if (bus.res_valid && bus.res_ready) begin
      n_res++;
      hs_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_y", {24'd0, bus.res_y}, {24'd0, e.y});
        check("sb_carry", {31'd0, bus.res_carry}, {31'd0, e.c});
        check("sb_zero", {31'd0, bus.res_zero}, {31'd0, e.z});
        check("sb_s", {29'd0, bus.res_s}, {29'd0, e.s});
      end
    end
    step();
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    bit ok;
    ok = 1'b0;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_s = s;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.cmd_ready) ok = 1'b1;
      step();
    end
    bus.cmd_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      step();
      n++;
    end
    if (!bus.res_valid) check("res_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_res_valid"}, {31'd0, bus.res_valid}, 32'd0);
    check({tag, "_alu_a"}, {24'd0, bus.alu_a}, 32'd0);
    check({tag, "_alu_b"}, {24'd0, bus.alu_b}, 32'd0);
    check({tag, "_alu_s"}, {29'd0, bus.alu_s}, 32'd0);
    check({tag, "_fifo_count"}, {29'd0, bus.fifo_count}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    int   n;
    int   k;
    bit   acc;
    bit   saw_valid;
    res_t r;

    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 8'd0;
    bus.cmd_b     = 8'd0;
    bus.cmd_s     = 3'd0;
    bus.res_ready = 1'b0;

    vecs[0]  = '{a: 8'd10,   b: 8'd10,   s: 3'd0, exp_y: 8'd20,   exp_c: 1'b0, exp_z: 1'b0};
    vecs[1]  = '{a: 8'hFF,   b: 8'h01,   s: 3'd0, exp_y: 8'h00,   exp_c: 1'b1, exp_z: 1'b1};
    vecs[2]  = '{a: 8'hF0,   b: 8'h20,   s: 3'd0, exp_y: 8'h10,   exp_c: 1'b1, exp_z: 1'b0};
    vecs[3]  = '{a: 8'h30,   b: 8'h10,   s: 3'd1, exp_y: 8'h20,   exp_c: 1'b0, exp_z: 1'b0};
    vecs[4]  = '{a: 8'h10,   b: 8'h30,   s: 3'd1, exp_y: 8'hE0,   exp_c: 1'b1, exp_z: 1'b0};
    vecs[5]  = '{a: 8'hF0,   b: 8'h0F,   s: 3'd2, exp_y: 8'h00,   exp_c: 1'b0, exp_z: 1'b1};
    vecs[6]  = '{a: 8'hF0,   b: 8'h0F,   s: 3'd3, exp_y: 8'hFF,   exp_c: 1'b0, exp_z: 1'b0};
    vecs[7]  = '{a: 8'hAA,   b: 8'hAA,   s: 3'd4, exp_y: 8'h00,   exp_c: 1'b0, exp_z: 1'b1};
    vecs[8]  = '{a: 8'h00,   b: 8'h55,   s: 3'd5, exp_y: 8'hFF,   exp_c: 1'b0, exp_z: 1'b0};
    vecs[9]  = '{a: 8'h81,   b: 8'h00,   s: 3'd6, exp_y: 8'h02,   exp_c: 1'b1, exp_z: 1'b0};
    vecs[10] = '{a: 8'h01,   b: 8'h00,   s: 3'd7, exp_y: 8'h00,   exp_c: 1'b1, exp_z: 1'b1};

    // Power-on reset
    step();
    step();
    check_reset_state("por");
    rst_n = 1'b1;
    step();

    // Single commands from the table, checking latency and captured fields
    foreach (vecs[i]) begin
      send_cmd(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_res(n);
      check("vec_latency", n, 32'd2);
      check("vec_y", {24'd0, bus.res_y}, {24'd0, vecs[i].exp_y});
      check("vec_carry", {31'd0, bus.res_carry}, {31'd0, vecs[i].exp_c});
      check("vec_zero", {31'd0, bus.res_zero}, {31'd0, vecs[i].exp_z});
      check("vec_s", {29'd0, bus.res_s}, {29'd0, vecs[i].s});
      check("vec_alu_a_held", {24'd0, bus.alu_a}, {24'd0, vecs[i].a});
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      check("vec_valid_drop", {31'd0, bus.res_valid}, 32'd0);
      check("vec_idle", {31'd0, bus.busy}, 32'd0);
    end

    // Reset asserted while busy
    send_cmd(8'd1, 8'd2, 3'd0);
    send_cmd(8'd3, 8'd4, 3'd0);
    check("busy_before_reset", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    check_reset_state("busy_rst");
    step();
    rst_n = 1'b1;
    step();

    // Backpressure: 5 commands absorbed, 6th refused, then all drain in order
    exp_q.delete();
    prev_hold = 1'b0;
    n_res = 0;
    k = 0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.cmd_valid = (k < 6);
      bus.cmd_a = 8'(k * 17 + 1);
      bus.cmd_b = 8'(k * 3 + 2);
      bus.cmd_s = 3'd0;
      acc = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (acc) k++;
    end
    r = model(8'd1, 8'd2, 3'd0);
    check("bp_accepted", k, 32'd5);
    check("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("bp_fifo_count", {29'd0, bus.fifo_count}, 32'd4);
    check("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
    check("bp_first_y", {24'd0, bus.res_y}, {24'd0, r.y});
    bus.res_ready = 1'b1;
    for (int i = 0; i < 60 && !(k == 6 && exp_q.size() == 0 && !bus.busy && !bus.res_valid); i++) begin
      bus.cmd_valid = (k < 6);
      bus.cmd_a = 8'(k * 17 + 1);
      bus.cmd_b = 8'(k * 3 + 2);
      acc = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (acc) k++;
    end
    bus.cmd_valid = 1'b0;
    check("bp_all_accepted", k, 32'd6);
    check("bp_results", n_res, 32'd6);
    check("bp_drained", exp_q.size(), 32'd0);

    // Streaming throughput: one result every two cycles, selects in order
    exp_q.delete();
    hs_q.delete();
    prev_hold = 1'b0;
    n_res = 0;
    k = 0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 60 && n_res < 8; i++) begin
      bus.cmd_valid = (k < 8);
      bus.cmd_a = 8'd10;
      bus.cmd_b = 8'd10;
      bus.cmd_s = 3'(k);
      acc = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (acc) k++;
    end
    bus.cmd_valid = 1'b0;
    check("tp_results", n_res, 32'd8);
    for (int i = 1; i < hs_q.size(); i++) begin
      check("tp_spacing", hs_q[i] - hs_q[i-1], 32'd2);
    end
    step();
    step();

    // Reset pulse while the command is settling
    bus.res_ready = 1'b0;
    send_cmd(8'd5, 8'd6, 3'd0);
    step();
    check("mid_alu_a", {24'd0, bus.alu_a}, 32'd5);
    check("mid_valid_pre", {31'd0, bus.res_valid}, 32'd0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.res_valid) saw_valid = 1'b1;
    end
    check("mid_no_valid", {31'd0, saw_valid}, 32'd0);
    check("mid_idle", {31'd0, bus.busy}, 32'd0);
    send_cmd(8'd7, 8'd8, 3'd0);
    wait_res(n);
    check("mid_latency", n, 32'd2);
    check("mid_y", {24'd0, bus.res_y}, 32'd15);
    bus.res_ready = 1'b1;
    step();

    // Randomized traffic against the queue model
    exp_q.delete();
    prev_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_a     = 8'($urandom);
      bus.cmd_b     = 8'($urandom);
      bus.cmd_s     = 3'($urandom);
      bus.res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 60 && (exp_q.size() != 0 || bus.busy || bus.res_valid); i++) begin
      tick();
    end
    check("rand_drained", exp_q.size(), 32'd0);
    check("rand_idle", {31'd0, bus.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
